// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// Groups the ALU result port, the load/multiply result port, the register-file
// write port and the status outputs of wb_arbiter.
//   master : result producers / register file side (drives alu_*, ld_*)
//   slave  : the arbiter (drives alu_stall, ld_ready, *_WB, wb_idle, fifo_cnt)
// Parameters: DEPTH (load FIFO entries), DATA_W (result width).
interface wb_arbiter_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              alu_we;
  logic [4:0]        alu_dst;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stall;

  logic              ld_valid;
  logic [4:0]        ld_dst;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  logic [4:0]        dst_reg_WB;
  logic [DATA_W-1:0] dst_reg_data_WB;
  logic              we_WB;
  logic              wb_idle;
  logic [CntW-1:0]   fifo_cnt;

  modport master (
    output alu_we, alu_dst, alu_data, ld_valid, ld_dst, ld_data,
    input  alu_stall, ld_ready, dst_reg_WB, dst_reg_data_WB, we_WB, wb_idle, fifo_cnt
  );

  modport slave (
    input  alu_we, alu_dst, alu_data, ld_valid, ld_dst, ld_data,
    output alu_stall, ld_ready, dst_reg_WB, dst_reg_data_WB, we_WB, wb_idle, fifo_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback-stage arbiter for the single register-file write port.
// Merges the single-cycle ALU result with the variable-latency load/multiply
// result. Loads that lose arbitration wait in an in-order FIFO of DEPTH entries.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (drops buffered loads)
//   bus  : wb_arbiter_if.slave - ALU port (alu_we/dst/data, alu_stall),
//          load port (ld_valid/dst/data, ld_ready), register-file write port
//          (dst_reg_WB, dst_reg_data_WB, we_WB), wb_idle and fifo_cnt status.
// Build option: define WB_BYPASS_EN to let a lone load with an empty FIFO and
// no ALU write go straight to the write port without being enqueued.
module wb_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {GntNone, GntAlu, GntFifo, GntLoad} gnt_e;

  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]        mem_dst_q  [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic              we_q;
  logic [4:0]        dst_q, dst_d;
  logic [DATA_W-1:0] data_q, data_d;

  gnt_e gnt;
  logic full, empty, ld_acc, enq, deq;

  assign full   = (count_q == CntW'(DEPTH));
  assign empty  = (count_q == '0);
  assign ld_acc = bus.ld_valid & ~full;

  assign bus.ld_ready        = ~full;
  assign bus.alu_stall       = full & bus.alu_we;
  assign bus.wb_idle         = empty & ~we_q;
  assign bus.fifo_cnt        = count_q;
  assign bus.we_WB           = we_q;
  assign bus.dst_reg_WB      = dst_q;
  assign bus.dst_reg_data_WB = data_q;

  // Fixed priority; a full FIFO always wins so it can never starve.
  always_comb begin
    gnt = GntNone;
    if (full) begin
      gnt = GntFifo;
    end else if (bus.alu_we && (bus.alu_dst != 5'd0)) begin
      gnt = GntAlu;
    end else if (!empty) begin
      gnt = GntFifo;
`ifdef WB_BYPASS_EN
    end else if (ld_acc && (bus.ld_dst != 5'd0)) begin
      gnt = GntLoad;
`endif
    end
  end

  // R0 loads are accepted but never stored.
  assign deq = (gnt == GntFifo);
  assign enq = ld_acc & (bus.ld_dst != 5'd0) & (gnt != GntLoad);

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Address/data hold their last value when nothing is granted.
  always_comb begin
    dst_d  = dst_q;
    data_d = data_q;
    case (gnt)
      GntAlu: begin
        dst_d  = bus.alu_dst;
        data_d = bus.alu_data;
      end
      GntFifo: begin
        dst_d  = mem_dst_q[rd_ptr_q];
        data_d = mem_data_q[rd_ptr_q];
      end
      GntLoad: begin
        dst_d  = bus.ld_dst;
        data_d = bus.ld_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      we_q     <= 1'b0;
      dst_q    <= '0;
      data_q   <= '0;
    end else begin
      count_q <= count_d;
      if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      we_q   <= (gnt != GntNone);
      dst_q  <= dst_d;
      data_q <= data_d;
    end
  end

  // Storage needs no reset: pointers and count are cleared, so stale entries
  // are unreachable.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_dst_q[wr_ptr_q]  <= bus.ld_dst;
      mem_data_q[wr_ptr_q] <= bus.ld_data;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_wb_arbiter;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;

  logic clk;
  logic rst;

  wb_arbiter_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs for one cycle plus the outputs expected while
  // those inputs are applied (registered outputs reflect the previous cycle).
  typedef struct {
    logic        rst;
    logic        aw;
    logic [4:0]  ad;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  ldd;
    logic [31:0] ldat;
    logic        e_we;
    logic [4:0]  e_dst;
    logic [31:0] e_data;
    logic [3:0]  e_cnt;
    logic        e_ready;
    logic        e_stall;
    logic        e_idle;
  } vec_t;

  vec_t vecs[11];

  task automatic drive(input logic r, input logic aw, input logic [4:0] ad,
                       input logic [DATA_W-1:0] adat, input logic lv,
                       input logic [4:0] ldd, input logic [DATA_W-1:0] ldat);
    rst          = r;
    bus.alu_we   = aw;
    bus.alu_dst  = ad;
    bus.alu_data = adat;
    bus.ld_valid = lv;
    bus.ld_dst   = ldd;
    bus.ld_data  = ldat;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    drive(v.rst, v.aw, v.ad, v.adat, v.lv, v.ldd, v.ldat);
    #4;
    chk($sformatf("vec%0d we_WB", i), bus.we_WB, v.e_we);
    chk($sformatf("vec%0d dst_reg_WB", i), bus.dst_reg_WB, v.e_dst);
    chk($sformatf("vec%0d dst_reg_data_WB", i), bus.dst_reg_data_WB, v.e_data);
    chk($sformatf("vec%0d fifo_cnt", i), bus.fifo_cnt, v.e_cnt);
    chk($sformatf("vec%0d ld_ready", i), bus.ld_ready, v.e_ready);
    chk($sformatf("vec%0d alu_stall", i), bus.alu_stall, v.e_stall);
    chk($sformatf("vec%0d wb_idle", i), bus.wb_idle, v.e_idle);
    @(posedge clk);
    #1;
  endtask

  // Reference model: pending loads as a queue, plus the expected write port.
  typedef struct packed {
    logic [4:0]        dst;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              q[$];
  logic              m_we;
  logic [4:0]        m_dst;
  logic [DATA_W-1:0] m_data;
  bit                last_stall;
  bit                last_block;

  task automatic step(input logic r, input logic aw, input logic [4:0] ad,
                      input logic [DATA_W-1:0] adat, input logic lv,
                      input logic [4:0] ldd, input logic [DATA_W-1:0] ldat,
                      input bit do_chk);
    int   sz;
    bit   ready, stall, acc, bypass;
    ent_t e;
    drive(r, aw, ad, adat, lv, ldd, ldat);
    #4;
    sz    = q.size();
    ready = (sz < DEPTH);
    stall = (sz == DEPTH) && aw;
    if (do_chk) begin
      chk("model we_WB", bus.we_WB, m_we);
      chk("model dst_reg_WB", bus.dst_reg_WB, m_dst);
      chk("model dst_reg_data_WB", bus.dst_reg_data_WB, m_data);
      chk("model fifo_cnt", bus.fifo_cnt, sz);
      chk("model ld_ready", bus.ld_ready, ready);
      chk("model alu_stall", bus.alu_stall, stall);
      chk("model wb_idle", bus.wb_idle, (sz == 0) && !m_we);
    end
    last_stall = stall;
    last_block = lv && !ready;
    if (r) begin
      q.delete();
      m_we   = 1'b0;
      m_dst  = '0;
      m_data = '0;
    end else begin
      acc    = lv && ready;
      bypass = 1'b0;
      m_we   = 1'b0;
      if (sz == DEPTH) begin
        e = q.pop_front();
        m_we = 1'b1; m_dst = e.dst; m_data = e.data;
      end else if (aw && ad != 5'd0) begin
        m_we = 1'b1; m_dst = ad; m_data = adat;
      end else if (sz > 0) begin
        e = q.pop_front();
        m_we = 1'b1; m_dst = e.dst; m_data = e.data;
`ifdef WB_BYPASS_EN
      end else if (acc && ldd != 5'd0) begin
        m_we = 1'b1; m_dst = ldd; m_data = ldat; bypass = 1'b1;
`endif
      end
      if (acc && ldd != 5'd0 && !bypass) q.push_back('{dst: ldd, data: ldat});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1);
  endtask

  initial begin
    logic              aw, lv, r;
    logic [4:0]        ad, ldd;
    logic [DATA_W-1:0] adat, ldat;

    vecs[0]  = '{1, 1, 5, 32'h1234,     1, 7, 32'h5678, 0, 0, 32'h0,        0, 1, 0, 1};
    vecs[1]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,    0, 0, 32'h0,        0, 1, 0, 1};
    vecs[2]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 5, 32'hDEADBEEF, 0, 1, 0, 0};
    vecs[3]  = '{0, 1, 3, 32'h11,       1, 7, 32'h22,   0, 5, 32'hDEADBEEF, 0, 1, 0, 1};
    vecs[4]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 3, 32'h11,       1, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 7, 32'h22,       0, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 32'h0,        1, 9, 32'h33,   0, 7, 32'h22,       0, 1, 0, 1};
`ifdef WB_BYPASS_EN
    vecs[7]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 9, 32'h33,       0, 1, 0, 0};
    vecs[8]  = '{0, 1, 0, 32'hAAAA,     1, 0, 32'hBBBB, 0, 9, 32'h33,       0, 1, 0, 1};
`else
    vecs[7]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 7, 32'h22,       1, 1, 0, 0};
    vecs[8]  = '{0, 1, 0, 32'hAAAA,     1, 0, 32'hBBBB, 1, 9, 32'h33,       0, 1, 0, 0};
`endif
    vecs[9]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 9, 32'h33,       0, 1, 0, 1};
    vecs[10] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 9, 32'h33,       0, 1, 0, 1};

    // First reset edge with both sources active; state is unknown before it.
    drive(1'b1, 1'b1, 5'd5, 32'h1234, 1'b1, 5'd7, 32'h5678);
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) apply_vec(i);

    // Resynchronise the model with a reset cycle.
    step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);

    // Fill: ALU busy every cycle while loads 10..13 arrive back to back.
    step(1'b0, 1'b1, 5'd1, 32'h101, 1'b1, 5'd10, 32'hA10, 1'b1);
    step(1'b0, 1'b1, 5'd2, 32'h102, 1'b1, 5'd11, 32'hA11, 1'b1);
    step(1'b0, 1'b1, 5'd3, 32'h103, 1'b1, 5'd12, 32'hA12, 1'b1);
    step(1'b0, 1'b1, 5'd4, 32'h104, 1'b1, 5'd13, 32'hA13, 1'b1);
    chk("fill fifo_cnt", bus.fifo_cnt, 4);
    chk("fill ld_ready", bus.ld_ready, 0);
    chk("fill alu_stall", bus.alu_stall, 1);
    chk("fill last alu dst", bus.dst_reg_WB, 4);
    step(1'b0, 1'b1, 5'd5, 32'h105, 1'b0, 5'd0, '0, 1'b1);
    chk("full grant dst", bus.dst_reg_WB, 10);
    chk("full grant data", bus.dst_reg_data_WB, 32'hA10);
    chk("full grant cnt", bus.fifo_cnt, 3);
    // Stalled ALU result is re-presented and must be written.
    step(1'b0, 1'b1, 5'd5, 32'h105, 1'b0, 5'd0, '0, 1'b1);
    chk("held alu dst", bus.dst_reg_WB, 5);
    chk("held alu data", bus.dst_reg_data_WB, 32'h105);
    for (int i = 0; i < 3; i++) begin
      idle_step();
      chk($sformatf("drain%0d we", i), bus.we_WB, 1);
      chk($sformatf("drain%0d dst", i), bus.dst_reg_WB, 11 + i);
    end
    idle_step();
    chk("drained we", bus.we_WB, 0);
    chk("drained cnt", bus.fifo_cnt, 0);

    // Reset with three loads pending.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 5'(20 + i), 32'(i), 1'b1, 5'(24 + i), 32'(100 + i), 1'b1);
    chk("pre-reset cnt", bus.fifo_cnt, 3);
    step(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1);
    chk("post-reset cnt", bus.fifo_cnt, 0);
    chk("post-reset idle", bus.wb_idle, 1);
    for (int i = 0; i < 5; i++) begin
      idle_step();
      chk($sformatf("post-reset%0d we", i), bus.we_WB, 0);
    end

    // Randomized traffic; producers hold a result that was not taken.
    last_stall = 1'b0;
    last_block = 1'b0;
    aw = 1'b0; ad = '0; adat = '0; lv = 1'b0; ldd = '0; ldat = '0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 249) == 0);
      if (!last_stall) begin
        aw   = ($urandom_range(0, 99) < 65);
        ad   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        adat = $urandom;
      end
      if (!last_block) begin
        lv   = ($urandom_range(0, 99) < 45);
        ldd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ldat = $urandom;
      end
      step(r, aw, ad, adat, lv, ldd, ldat, 1'b1);
      if (r) begin
        last_stall = 1'b0;
        last_block = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-stage arbiter in front of the register file's single write port.
- Merges two result sources: the single-cycle ALU pipe and the variable-latency load/multiply unit.
- Load results that lose arbitration wait in a small in-order FIFO; drives dst_reg_WB / dst_reg_data_WB / we_WB straight into the register file.
- Upstream scoreboard guarantees no WAW hazard between the two sources.

Parameters:
DEPTH, 4, load FIFO entries; power of two, >=2
DATA_W, 32, result data width

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
alu_we  input  1  ALU result valid this cycle
alu_dst  input  5  ALU destination register
alu_data  input  DATA_W  ALU result
alu_stall  output  1  ALU result not taken this cycle; upstream must hold and re-present it
ld_valid  input  1  load/mul result valid
ld_dst  input  5  load destination register
ld_data  input  DATA_W  load result
ld_ready  output  1  arbiter accepts a load result this cycle
dst_reg_WB  output  5  register file write address
dst_reg_data_WB  output  DATA_W  register file write data
we_WB  output  1  register file write enable
wb_idle  output  1  FIFO empty and no write in flight
fifo_cnt  output  log2(DEPTH)+1  FIFO occupancy (debug)

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: we_WB=0, dst_reg_WB=0, dst_reg_data_WB=0, FIFO count and pointers 0. Buffered entries are discarded.
  - Reset mid-operation drops all pending loads; no write issues the cycle after reset.
- Combinational outputs, from registered count:
  - ld_ready = (count < DEPTH).
  - alu_stall = (count == DEPTH) & alu_we.
  - wb_idle = (count == 0) & ~we_WB.
  - ld_acc = ld_valid & ld_ready.
- Grant priority, evaluated each cycle, first match wins:
  1. count == DEPTH: grant FIFO head. ALU is stalled, its result is not written.
  2. alu_we & (alu_dst != 0): grant ALU.
  3. count > 0: grant FIFO head.
  4. WB_BYPASS_EN only: ld_acc & (ld_dst != 0) & (count == 0): grant the incoming load directly (bypass).
  5. Otherwise: no grant.
- Output register, updated on the next rising edge:
  - On any grant: we_WB<=1, dst_reg_WB and dst_reg_data_WB <= granted source. Latency is 1 cycle.
  - No grant: we_WB<=0; dst_reg_WB and dst_reg_data_WB hold their last values.
- FIFO enqueue: ld_acc & (ld_dst != 0) & not bypassed. Entry = {ld_dst, ld_data} at the write pointer.
- FIFO dequeue: when the FIFO head is granted. Entries leave strictly in arrival order.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - Enqueue with count==DEPTH is impossible, because ld_ready is low.
- Pointers wrap modulo DEPTH. Count saturates by construction, range 0..DEPTH.
- Register 0: alu_dst==0 or ld_dst==0 never produces a write.
  - An R0 load is still accepted (ld_ready honoured) and dropped.
  - An R0 ALU result is consumed, and is stalled only when the FIFO is full.
- Starvation bound: the FIFO gets the port at least once every cycle it is full. The ALU is stalled at most 1 consecutive cycle per full event.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: priority rule 4 is active. A lone load with an empty FIFO and no ALU write reaches we_WB 1 cycle after ld_valid, and is never enqueued.
- Undefined: every accepted non-R0 load is enqueued first. Minimum load-to-we_WB latency is 2 cycles.
- ALU path and all other rules are identical in both builds.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with ld_valid=1 and alu_we=1 -> we_WB=0, dst_reg_WB=0, dst_reg_data_WB=0, fifo_cnt=0, ld_ready=1, alu_stall=0, wb_idle=1.
2. Single ALU write: alu_we=1, alu_dst=5, alu_data=0xDEADBEEF for one cycle -> next cycle we_WB=1, dst_reg_WB=5, dst_reg_data_WB=0xDEADBEEF; following cycle we_WB=0.
3. Collision: same cycle ALU (dst 3, 0x11) and load (dst 7, 0x22) -> cycle+1 writes R3=0x11, cycle+2 writes R7=0x22. Separately, a lone load (dst 9, 0x33) writes at cycle+1 with WB_BYPASS_EN and at cycle+2 without it.
4. Fill/back-pressure: ALU writes every cycle (dst 1..) while loads dst 10..13 arrive back-to-back -> fifo_cnt reaches 4, ld_ready=0, alu_stall=1. Next cycle writes R10; FIFO then drains R11, R12, R13 in order as ALU traffic permits, with no ALU result lost.
5. R0 handling: alu_we=1, alu_dst=0, plus ld_valid=1, ld_dst=0 -> ld_ready=1, we_WB stays 0, fifo_cnt stays 0.
6. Reset mid-op: fifo_cnt=3, assert rst one cycle -> fifo_cnt=0, wb_idle=1, and no write of the discarded entries in the following 5 cycles.
